// File: rtl/sm_alu_seq.sv
// rtl/sm_alu_seq.sv - handshaked sign-magnitude ALU with iterative multiply and divide
// Optional restoring divider built when SM_ALU_DIV_EN is defined; otherwise opcode 00011 is illegal.
module sm_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALU_CONTROL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic             C,
  output logic             err
);
  localparam int M = WIDTH - 1;

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b01000, OP_OR   = 5'b01001, OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_NOR  = 5'b01011, OP_NAND = 5'b01100, OP_XNOR = 5'b01101;
  localparam logic [4:0] OP_EQ   = 5'b10000, OP_LT   = 5'b10001, OP_GT   = 5'b10010;
  localparam logic [4:0] OP_LSL  = 5'b11000, OP_LSR  = 5'b11001, OP_ASR  = 5'b11010;
  localparam logic [4:0] OP_REV  = 5'b11011;
`ifdef SM_ALU_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b00011;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2*M-1:0]   p_q, p_d;
  logic [M-1:0]     opnd_q, opnd_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             sign_y_q, sign_y_d;
  logic [WIDTH-1:0] y_q, y_d, r_q, r_d;
  logic             z_q, z_d, v_q, v_d, n_q, n_d, c_q, c_d, err_q, err_d;
`ifdef SM_ALU_DIV_EN
  logic             div_q, div_d;
  logic             sign_a_q, sign_a_d;
  logic [M:0]       div_trial, div_diff;
`endif

  logic             op_mul, op_div;
  logic             sa, sb_eff, neg_a, neg_b, eq_r, lt_r, gt_r;
  logic [M-1:0]     ma, mb, add_mag;
  logic [M:0]       add_sum;
  logic             add_sign, add_carry;
  logic [SHW-1:0]   sh;
  logic             sh_big;
  logic [WIDTH:0]   lsl_ext, lsr_ext, asr_ext;
  logic [WIDTH-1:0] rev_a, sc_y;
  logic             sc_arith, sc_v, sc_c, sc_err, sc_z, sc_n;
  logic [M:0]       mul_sum;
  logic [2*M-1:0]   p_step;
  logic [M-1:0]     fin_mag;
  logic             fin_v;
  logic [WIDTH-1:0] fin_y, fin_r;

  assign op_mul = (ALU_CONTROL == OP_MUL);
`ifdef SM_ALU_DIV_EN
  assign op_div = (ALU_CONTROL == OP_DIV);
`else
  assign op_div = 1'b0;
`endif

  assign ma     = A[M-1:0];
  assign mb     = B[M-1:0];
  assign sa     = A[WIDTH-1];
  assign sb_eff = B[WIDTH-1] ^ (ALU_CONTROL == OP_SUB);

  always_comb begin
    add_sum   = '0;
    add_mag   = '0;
    add_sign  = 1'b0;
    add_carry = 1'b0;
    if (sa == sb_eff) begin
      add_sum   = {1'b0, ma} + {1'b0, mb};
      add_mag   = add_sum[M-1:0];
      add_carry = add_sum[M];
      add_sign  = sa;
    end else if (ma >= mb) begin
      add_mag  = ma - mb;
      add_sign = sa;
    end else begin
      add_mag  = mb - ma;
      add_sign = sb_eff;
    end
    if (add_mag == '0) add_sign = 1'b0;
  end

  // Zero magnitudes count as non-negative so -0 and +0 order equal.
  assign neg_a = sa & (|ma);
  assign neg_b = B[WIDTH-1] & (|mb);
  assign eq_r  = (ma == mb) && ((sa == B[WIDTH-1]) || (ma == '0));
  assign lt_r  = (neg_a != neg_b) ? neg_a : (neg_a ? (ma > mb) : (ma < mb));
  assign gt_r  = !eq_r && !lt_r;

  assign sh      = B[SHW-1:0];
  assign sh_big  = (|B[WIDTH-1:SHW]) || ({1'b0, sh} >= (SHW+1)'(WIDTH));
  assign lsl_ext = {1'b0, A} << sh;
  assign lsr_ext = {A, 1'b0} >> sh;
  assign asr_ext = $signed({A, 1'b0}) >>> sh;

  always_comb begin
    rev_a = '0;
    for (int i = 0; i < WIDTH; i++) rev_a[i] = A[WIDTH-1-i];
  end

  always_comb begin
    sc_y     = '0;
    sc_arith = 1'b0;
    sc_v     = 1'b0;
    sc_c     = 1'b0;
    sc_err   = 1'b0;
    case (ALU_CONTROL)
      OP_ADD, OP_SUB: begin
        sc_y     = {add_sign, add_mag};
        sc_v     = add_carry;
        sc_c     = add_carry;
        sc_arith = 1'b1;
      end
      OP_MUL: sc_arith = 1'b1;
`ifdef SM_ALU_DIV_EN
      OP_DIV: sc_arith = 1'b1;
`endif
      OP_AND:  sc_y = A & B;
      OP_OR:   sc_y = A | B;
      OP_XOR:  sc_y = A ^ B;
      OP_NOR:  sc_y = ~(A | B);
      OP_NAND: sc_y = ~(A & B);
      OP_XNOR: sc_y = ~(A ^ B);
      OP_EQ: begin
        sc_y     = eq_r ? WIDTH'(1) : '0;
        sc_arith = 1'b1;
      end
      OP_LT: begin
        sc_y     = lt_r ? WIDTH'(2) : '0;
        sc_arith = 1'b1;
      end
      OP_GT: begin
        sc_y     = gt_r ? WIDTH'(4) : '0;
        sc_arith = 1'b1;
      end
      OP_LSL: if (!sh_big) begin
        sc_y = lsl_ext[WIDTH-1:0];
        sc_c = lsl_ext[WIDTH];
      end
      OP_LSR: if (!sh_big) begin
        sc_y = lsr_ext[WIDTH:1];
        sc_c = lsr_ext[0];
      end
      OP_ASR: begin
        if (sh_big) begin
          sc_y = {WIDTH{A[WIDTH-1]}};
        end else begin
          sc_y = asr_ext[WIDTH:1];
          sc_c = asr_ext[0];
        end
      end
      OP_REV:  sc_y = rev_a;
      default: sc_err = 1'b1;
    endcase
    sc_z = !sc_err && (sc_arith ? (sc_y[M-1:0] == '0) : (sc_y == '0));
    sc_n = !sc_err && sc_y[WIDTH-1];
  end

  // p holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum = {1'b0, p_q[2*M-1:M]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    p_step  = {mul_sum, p_q[M-1:1]};
`ifdef SM_ALU_DIV_EN
    div_trial = p_q[2*M-1:M-1];
    div_diff  = div_trial - {1'b0, opnd_q};
    if (div_q) begin
      if (div_diff[M]) p_step = {div_trial[M-1:0], p_q[M-2:0], 1'b0};
      else             p_step = {div_diff[M-1:0],  p_q[M-2:0], 1'b1};
    end
`endif
  end

  always_comb begin
    fin_mag = p_step[M-1:0];
    fin_v   = |p_step[2*M-1:M];
    fin_r   = '0;
`ifdef SM_ALU_DIV_EN
    if (div_q) begin
      fin_v = (opnd_q == '0);
      if (fin_v) fin_mag = '0;
      else       fin_r   = {sign_a_q & (|p_step[2*M-1:M]), p_step[2*M-1:M]};
    end
`endif
    fin_y = {sign_y_q & (|fin_mag), fin_mag};
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    sign_y_d = sign_y_q;
    y_d      = y_q;
    r_d      = r_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    c_d      = c_q;
    err_d    = err_q;
`ifdef SM_ALU_DIV_EN
    div_d    = div_q;
    sign_a_d = sign_a_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        if (op_mul || op_div) begin
          state_d  = S_EXEC;
          cnt_d    = '0;
          opnd_d   = op_div ? mb : ma;
          p_d      = {{M{1'b0}}, op_div ? ma : mb};
          sign_y_d = A[WIDTH-1] ^ B[WIDTH-1];
`ifdef SM_ALU_DIV_EN
          div_d    = op_div;
          sign_a_d = A[WIDTH-1];
`endif
        end else begin
          state_d = S_DONE;
          y_d     = sc_y;
          r_d     = '0;
          z_d     = sc_z;
          v_d     = sc_v;
          n_d     = sc_n;
          c_d     = sc_c;
          err_d   = sc_err;
        end
      end
      S_EXEC: begin
        p_d   = p_step;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(M-1)) begin
          state_d = S_DONE;
          y_d     = fin_y;
          r_d     = fin_r;
          z_d     = (fin_mag == '0);
          v_d     = fin_v;
          n_d     = fin_y[WIDTH-1];
          c_d     = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      sign_y_q <= 1'b0;
      y_q      <= '0;
      r_q      <= '0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      err_q    <= 1'b0;
`ifdef SM_ALU_DIV_EN
      div_q    <= 1'b0;
      sign_a_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      sign_y_q <= sign_y_d;
      y_q      <= y_d;
      r_q      <= r_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
      c_q      <= c_d;
      err_q    <= err_d;
`ifdef SM_ALU_DIV_EN
      div_q    <= div_d;
      sign_a_q <= sign_a_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Y   = y_q;
  assign R   = r_q;
  assign Z   = z_q;
  assign V   = v_q;
  assign N   = n_q;
  assign C   = c_q;
  assign err = err_q;

endmodule

// File: tb/tb_sm_alu_seq.sv
// tb/tb_sm_alu_seq.sv - randomized self-checking bench for sm_alu_seq
// Expected results come from integer arithmetic on decoded sign-magnitude values.
module tb_sm_alu_seq;
  localparam int W = 32;
  localparam longint TWO31 = 64'sh8000_0000;
`ifdef SM_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010, OP_DIV = 5'b00011;
  localparam logic [4:0] OP_EQ  = 5'b10000, OP_LT  = 5'b10001, OP_GT  = 5'b10010;
  localparam logic [4:0] OP_LSL = 5'b11000, OP_LSR = 5'b11001, OP_ASR = 5'b11010, OP_REV = 5'b11011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  A, B, Y, R;
  logic [4:0]    ALU_CONTROL;
  logic          Z, V, N, C, err;

  typedef struct packed {
    logic [31:0] y;
    logic [31:0] r;
    logic z, v, n, c, err;
  } res_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } stim_t;

  int n_total = 0;
  int n_pass  = 0;

  sm_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_CONTROL(ALU_CONTROL), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .R(R), .Z(Z), .V(V), .N(N), .C(C), .err(err)
  );

  always #5 clk = ~clk;

  function automatic longint sm_val(input logic [31:0] x);
    longint m;
    m = longint'({33'b0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

  function automatic res_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t   e;
    longint va, vb, s, mag, ma, mb, p, q, rm;
    longint unsigned amt;
    logic [63:0] w;
    bit     arith;
    int     k;
    e = '0;
    arith = 1'b0;
    ma = longint'({33'b0, a[30:0]});
    mb = longint'({33'b0, b[30:0]});
    va = sm_val(a);
    vb = sm_val(b);
    amt = longint'({32'b0, b});
    k = (amt < 32) ? int'(amt) : 0;
    case (op)
      OP_ADD, OP_SUB: begin
        s = (op == OP_ADD) ? va + vb : va - vb;
        mag = (s < 0) ? -s : s;
        e.c = (mag >= TWO31);
        e.v = e.c;
        mag = mag % TWO31;
        e.y = {(s < 0) && (mag != 0), mag[30:0]};
        arith = 1'b1;
      end
      OP_MUL: begin
        p = ma * mb;
        e.v = (p >= TWO31);
        p = p % TWO31;
        e.y = {(a[31] ^ b[31]) && (p != 0), p[30:0]};
        arith = 1'b1;
      end
      OP_DIV: begin
        if (!DIV_EN) begin
          e.err = 1'b1;
          return e;
        end
        if (mb == 0) begin
          e.v = 1'b1;
        end else begin
          q  = ma / mb;
          rm = ma % mb;
          e.y = {(a[31] ^ b[31]) && (q != 0), q[30:0]};
          e.r = {a[31] && (rm != 0), rm[30:0]};
        end
        arith = 1'b1;
      end
      5'b01000: e.y = a & b;
      5'b01001: e.y = a | b;
      5'b01010: e.y = a ^ b;
      5'b01011: e.y = ~(a | b);
      5'b01100: e.y = ~(a & b);
      5'b01101: e.y = ~(a ^ b);
      OP_EQ: begin e.y = (va == vb) ? 32'd1 : 32'd0; arith = 1'b1; end
      OP_LT: begin e.y = (va <  vb) ? 32'd2 : 32'd0; arith = 1'b1; end
      OP_GT: begin e.y = (va >  vb) ? 32'd4 : 32'd0; arith = 1'b1; end
      OP_LSL: if (amt < 32) begin
        w = {32'b0, a} << k;
        e.y = w[31:0];
        e.c = w[32];
      end
      OP_LSR: if (amt < 32) begin
        e.y = a >> k;
        e.c = (k != 0) && a[k-1];
      end
      OP_ASR: begin
        if (amt >= 32) begin
          e.y = a[31] ? 32'hFFFF_FFFF : 32'h0;
        end else begin
          e.y = $signed(a) >>> k;
          e.c = (k != 0) && a[k-1];
        end
      end
      OP_REV: for (int i = 0; i < 32; i++) e.y[i] = a[31-i];
      default: begin
        e.err = 1'b1;
        return e;
      end
    endcase
    e.z = arith ? (e.y[30:0] == 31'd0) : (e.y == 32'd0);
    e.n = e.y[31];
    return e;
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
    return (op == OP_MUL || (DIV_EN && op == OP_DIV)) ? W : 1;
  endfunction

  function automatic logic [31:0] rand_sm();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      1: v[30:0] = 31'($urandom_range(0, 3));
      2: v[30:0] = 31'($urandom_range(0, 300));
      3: v[30:16] = '0;
      default: ;
    endcase
    return v;
  endfunction

  // Issues one op with out_ready high and returns the captured result and cycles to out_valid.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output res_t got, output int lat, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    ALU_CONTROL = op;
    A = a;
    B = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) ok = 1'b0;
    got = {Y, R, Z, V, N, C, err};
  endtask

  task automatic run_list(input string name, input stim_t q[$]);
    res_t got, exp;
    int   lat;
    bit   ok;
    foreach (q[i]) begin
      do_op(q[i].op, q[i].a, q[i].b, got, lat, ok);
      exp = model(q[i].op, q[i].a, q[i].b);
      n_total++;
      if (!ok || got !== exp || lat != exp_lat(q[i].op))
        $display("FAIL %s[%0d] op=%b A=%h B=%h: got %h lat=%0d hs_ok=%0d, expected %h lat=%0d",
                 name, i, q[i].op, q[i].a, q[i].b, got, lat, ok, exp, exp_lat(q[i].op));
      else
        n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    ALU_CONTROL = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({in_ready, out_valid, Y, R, Z, V, N, C, err} !== {1'b1, 1'b0, 64'b0, 5'b0})
      $display("FAIL reset_state: got rdy=%b vld=%b Y=%h R=%h zvnc=%b%b%b%b err=%b, expected rdy=1 vld=0 all zero",
               in_ready, out_valid, Y, R, Z, V, N, C, err);
    else
      n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    else
      n_pass++;
  endtask

  task automatic test_add_sub();
    stim_t q[$];
    q.push_back('{OP_ADD, 32'h8000_0010, 32'h0000_0004});
    q.push_back('{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001});
    q.push_back('{OP_SUB, 32'h0000_0005, 32'h0000_0005});
    q.push_back('{OP_ADD, 32'h8000_0000, 32'h0000_0000});
    q.push_back('{OP_SUB, 32'h8000_0003, 32'h0000_0009});
    for (int i = 0; i < 40; i++) q.push_back('{($urandom_range(0, 1) != 0) ? OP_SUB : OP_ADD, rand_sm(), rand_sm()});
    run_list("add_sub", q);
  endtask

  task automatic test_logic();
    stim_t q[$];
    for (int i = 0; i < 18; i++) q.push_back('{5'(8 + (i % 6)), 32'($urandom), 32'($urandom)});
    q.push_back('{5'b01000, 32'h0F0F_0000, 32'hF0F0_FFFF});
    run_list("logic", q);
  endtask

  task automatic test_compare();
    stim_t q[$];
    logic [31:0] a;
    q.push_back('{OP_EQ, 32'h8000_0000, 32'h0000_0000});
    q.push_back('{OP_LT, 32'h8000_0030, 32'h0000_0004});
    q.push_back('{OP_GT, 32'h8000_0002, 32'h8000_0021});
    q.push_back('{OP_LT, 32'h8000_0000, 32'h0000_0000});
    q.push_back('{OP_GT, 32'h0000_0000, 32'h8000_0000});
    for (int i = 0; i < 24; i++) begin
      a = rand_sm();
      case ($urandom_range(0, 2))
        0: q.push_back('{5'(16 + (i % 3)), a, a});
        1: q.push_back('{5'(16 + (i % 3)), a, {~a[31], a[30:0]}});
        default: q.push_back('{5'(16 + (i % 3)), a, rand_sm()});
      endcase
    end
    run_list("compare", q);
  endtask

  task automatic test_shift();
    stim_t q[$];
    logic [31:0] amt;
    q.push_back('{OP_ASR, 32'h8000_05EA, 32'd8});
    q.push_back('{OP_LSL, 32'hFFFF_FFFF, 32'd40});
    q.push_back('{OP_LSR, 32'h8000_0001, 32'd0});
    q.push_back('{OP_ASR, 32'h8000_0000, 32'h0000_0100});
    q.push_back('{OP_REV, 32'h0000_0001, 32'd0});
    for (int i = 0; i < 32; i++) begin
      case ($urandom_range(0, 3))
        0: amt = 32'($urandom_range(0, 31));
        1: amt = 32'($urandom_range(32, 40));
        2: amt = $urandom;
        default: amt = 32'($urandom_range(1, 3));
      endcase
      q.push_back('{5'(24 + (i % 4)), 32'($urandom), amt});
    end
    run_list("shift", q);
  endtask

  task automatic test_mul();
    stim_t q[$];
    q.push_back('{OP_MUL, 32'h8000_0002, 32'h0000_0007});
    q.push_back('{OP_MUL, 32'h0001_0000, 32'h0001_0000});
    q.push_back('{OP_MUL, 32'h8000_0000, 32'h0000_1234});
    for (int i = 0; i < 6; i++) q.push_back('{OP_MUL, rand_sm(), rand_sm()});
    run_list("mul", q);
  endtask

  task automatic test_div();
    stim_t q[$];
    q.push_back('{OP_DIV, 32'd23, 32'd6});
    q.push_back('{OP_DIV, 32'h8000_0017, 32'h0000_0000});
    q.push_back('{OP_DIV, 32'h8000_0017, 32'h8000_0005});
    q.push_back('{OP_DIV, 32'h7FFF_FFFF, 32'h0000_0001});
    for (int i = 0; i < 5; i++) q.push_back('{OP_DIV, 32'($urandom), {1'($urandom_range(0, 1)), 31'($urandom_range(1, 5000))}});
    run_list("div", q);
  endtask

  task automatic test_illegal();
    stim_t q[$];
    logic [4:0] bad [12] = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd14, 5'd15, 5'd19, 5'd22, 5'd28, 5'd29, 5'd30, 5'd31};
    foreach (bad[i]) q.push_back('{bad[i], 32'($urandom), 32'($urandom)});
    run_list("illegal", q);
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, b1, a2, b2;
    res_t exp1, exp2, got;
    a1 = rand_sm();
    b1 = rand_sm();
    a2 = rand_sm();
    b2 = rand_sm();
    exp1 = model(OP_ADD, a1, b1);
    exp2 = model(OP_SUB, a2, b2);
    @(negedge clk);
    out_ready = 1'b0;
    ALU_CONTROL = OP_ADD;
    A = a1;
    B = b1;
    in_valid = 1'b1;
    @(negedge clk);
    ALU_CONTROL = OP_SUB;
    A = a2;
    B = b2;
    for (int i = 0; i < 4; i++) begin
      got = {Y, R, Z, V, N, C, err};
      n_total++;
      if (got !== exp1 || in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL backpressure_hold[%0d]: got %h rdy=%b vld=%b, expected %h rdy=0 vld=1",
                 i, got, in_ready, out_valid, exp1);
      else
        n_pass++;
      if (i < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL backpressure_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    else
      n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    got = {Y, R, Z, V, N, C, err};
    n_total++;
    if (got !== exp2 || out_valid !== 1'b1)
      $display("FAIL backpressure_next: got %h vld=%b, expected %h vld=1", got, out_valid, exp2);
    else
      n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    res_t got, exp;
    int   lat;
    bit   ok;
    @(negedge clk);
    ALU_CONTROL = OP_MUL;
    A = 32'h0000_1234;
    B = 32'h0000_5678;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Y !== 32'h0)
      $display("FAIL reset_mid_mul: got rdy=%b vld=%b Y=%h, expected rdy=1 vld=0 Y=0", in_ready, out_valid, Y);
    else
      n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_no_output: got vld=%b, expected vld=0", out_valid);
    else
      n_pass++;
    do_op(OP_MUL, 32'h8000_0003, 32'h0000_0005, got, lat, ok);
    exp = model(OP_MUL, 32'h8000_0003, 32'h0000_0005);
    n_total++;
    if (!ok || got !== exp || lat != W)
      $display("FAIL after_reset_mul: got %h lat=%0d hs_ok=%0d, expected %h lat=%0d", got, lat, ok, exp, W);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_compare();
    test_shift();
    test_mul();
    test_div();
    test_illegal();
    test_backpressure();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
